// File: rtl/game_sequencer.sv
// Game flow sequencer: loads amount/key per player, then runs animation rounds
// until MAX_ROUNDS are complete. Synchronous active-low reset.
module game_sequencer #(
    parameter int NUM_PLAYERS  = 2,
    parameter int ANIM_TIMEOUT = 1023,
    parameter int MAX_ROUNDS   = 8,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load_signal,
    input  logic          start_signal,
    input  logic          done,
    output logic          load_screen,
    output logic          load_amount,
    output logic          load_key,
    output logic [PW-1:0] player_sel,
    output logic          initialize_done,
    output logic          start_animation,
    output logic          anim_busy,
    output logic          anim_timeout,
    output logic [RW-1:0] round_count,
    output logic          game_over
);

    localparam int TW = (ANIM_TIMEOUT > 1) ? $clog2(ANIM_TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_AMT  = 3'd1;
    localparam logic [2:0] S_WAIT_KEY  = 3'd2;
    localparam logic [2:0] S_LOAD_KEY  = 3'd3;
    localparam logic [2:0] S_WAIT_AMT  = 3'd4;
    localparam logic [2:0] S_READY     = 3'd5;
    localparam logic [2:0] S_ANIM      = 3'd6;
    localparam logic [2:0] S_GAME_OVER = 3'd7;

    localparam logic [PW-1:0] LAST_P = PW'(NUM_PLAYERS - 1);
    localparam logic [TW-1:0] LAST_T = TW'(ANIM_TIMEOUT - 1);
    localparam logic [RW-1:0] LAST_R = RW'(MAX_ROUNDS - 1);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] player_q, player_d;
    logic [RW-1:0] round_q, round_d;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            player_q <= '0;
            round_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            round_q  <= round_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        round_d  = round_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (load_signal) begin
                    state_d  = S_LOAD_AMT;
                    player_d = '0;
                end
            end
            S_LOAD_AMT: if (!load_signal) state_d = S_WAIT_KEY;
            S_WAIT_KEY: if (load_signal) state_d = S_LOAD_KEY;
            S_LOAD_KEY: begin
                if (!load_signal) begin
                    if (player_q < LAST_P) begin
                        state_d  = S_WAIT_AMT;
                        player_d = player_q + PW'(1);
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            S_WAIT_AMT: if (load_signal) state_d = S_LOAD_AMT;
            S_READY: begin
                if (start_signal) begin
                    state_d = S_ANIM;
                    timer_d = '0;
                end
            end
            S_ANIM: begin
                // done and the final timeout cycle both end the round the same way
                if (done || timer_q == LAST_T) begin
                    timer_d = '0;
                    round_d = round_q + RW'(1);
                    state_d = (round_q == LAST_R) ? S_GAME_OVER : S_READY;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAME_OVER: begin
                if (start_signal) begin
                    state_d  = S_IDLE;
                    round_d  = '0;
                    player_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_screen     = (state_q == S_IDLE);
    assign load_amount     = (state_q == S_LOAD_AMT);
    assign load_key        = (state_q == S_LOAD_KEY);
    assign initialize_done = (state_q == S_READY);
    assign anim_busy       = (state_q == S_ANIM);
    assign game_over       = (state_q == S_GAME_OVER);
    assign start_animation = anim_busy && (timer_q == '0);
    assign anim_timeout    = anim_busy && !done && (timer_q == LAST_T);
    assign player_sel      = player_q;
    assign round_count     = round_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players loaded per game (legal 2..8).
REQ-002 Parameter ANIM_TIMEOUT, default 1023, max cycles spent in ANIM awaiting done (legal >=1).
REQ-003 Parameter MAX_ROUNDS, default 8, rounds per game before GAME_OVER (legal >=1).
REQ-004 Derived PW = max(1, clog2(NUM_PLAYERS)) and RW = clog2(MAX_ROUNDS+1).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 load_signal  input  1  level; high = load key held.
REQ-008 start_signal  input  1  level; high = start requested.
REQ-009 done  input  1  animation engine finished; sampled only in ANIM.
REQ-010 load_screen  output  1  high in IDLE: fetch player balances for display.
REQ-011 load_amount  output  1  high in LOAD_AMT: capture amount for player_sel.
REQ-012 load_key  output  1  high in LOAD_KEY: capture key for player_sel.
REQ-013 player_sel  output  PW  index of player currently being loaded.
REQ-014 initialize_done  output  1  high in READY.
REQ-015 start_animation  output  1  one-cycle pulse on first ANIM cycle.
REQ-016 anim_busy  output  1  high throughout ANIM.
REQ-017 anim_timeout  output  1  one-cycle pulse when ANIM exits by timeout.
REQ-018 round_count  output  RW  completed rounds in current game.
REQ-019 game_over  output  1  high in GAME_OVER.

Function
REQ-020 States SHALL be IDLE, LOAD_AMT, WAIT_KEY, LOAD_KEY, WAIT_AMT, READY, ANIM, GAME_OVER; one state register, all state/counters update on rising clock only.
REQ-021 IDLE: load_signal=1 -> LOAD_AMT with player_sel=0; else stay.
REQ-022 LOAD_AMT: stay while load_signal=1; load_signal=0 -> WAIT_KEY.
REQ-023 WAIT_KEY: load_signal=1 -> LOAD_KEY; else stay.
REQ-024 LOAD_KEY: stay while load_signal=1; on release, player_sel<NUM_PLAYERS-1 -> WAIT_AMT with player_sel+1, else -> READY.
REQ-025 WAIT_AMT: load_signal=1 -> LOAD_AMT; else stay.
REQ-026 READY: start_signal=1 -> ANIM with anim timer cleared to 0; else stay; load_signal ignored.
REQ-027 ANIM: timer increments each cycle; done=1 -> exit; timer reaching ANIM_TIMEOUT-1 with done=0 -> exit with anim_timeout pulse in that exit cycle.
REQ-028 Done and final timeout cycle coincident: done wins, no anim_timeout pulse.
REQ-029 Exit from ANIM (done or timeout) SHALL increment round_count; new value == MAX_ROUNDS -> GAME_OVER, else -> READY (players stay loaded).
REQ-030 GAME_OVER: start_signal=1 -> IDLE with round_count and player_sel cleared; else stay.
REQ-031 Outputs load_screen/load_amount/load_key/initialize_done/anim_busy/game_over SHALL be decoded from current state only (Moore, zero input-to-output path); exactly one state-flag high at any time, all low in WAIT_KEY/WAIT_AMT.
REQ-032 start_animation SHALL be high iff state==ANIM and timer==0.
REQ-033 round_count SHALL never exceed MAX_ROUNDS; player_sel SHALL never exceed NUM_PLAYERS-1.
REQ-034 Illegal state encoding SHALL transition to IDLE next cycle.

Reset
REQ-035 resetn=0 at a rising edge SHALL force IDLE, player_sel=0, round_count=0, timer=0 from any state, including mid-ANIM and mid-load.
REQ-036 During and after reset until first transition: load_screen=1, all other outputs 0.

Verification
REQ-037 Defaults, two load_signal pulses per player (4 total) -> load_amount/load_key high with player_sel 0,0,1,1; initialize_done=1 after fourth release.
REQ-038 READY, start_signal=1, done=1 five cycles later -> start_animation single pulse, anim_busy 6 cycles, round_count 0->1, back to READY.
REQ-039 ANIM_TIMEOUT=16, done held 0 -> anim_timeout pulse on 16th ANIM cycle, round_count+1, READY next.
REQ-040 done=1 exactly on timeout cycle -> no anim_timeout, normal exit.
REQ-041 MAX_ROUNDS=2: two rounds -> game_over=1, round_count=2; start_signal -> IDLE, round_count=0.
REQ-042 resetn=0 for one cycle mid-ANIM and mid-LOAD_KEY (player_sel=1) -> next cycle IDLE, load_screen=1, counters 0; NUM_PLAYERS=3 rerun of REQ-037 covers player_sel wrap limit.
